// File: rtl/cpu_debug_jtag_host_seq.sv
// ============================================================================
// Module   : cpu_debug_jtag_host_seq
// Brief    : Host-side virtual-JTAG DR sequencer driving a CPU debug slave.
//            Optional feature macro: DEBUG_HOST_IR_CACHE_EN (skip UIR when the
//            requested IR equals the last loaded IR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_debug_jtag_host_seq #(
    parameter int DR_W       = 38,
    parameter int IR_W       = 2,
    parameter int TCK_DIV    = 4,
    parameter int RTI_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [IR_W-1:0] cmd_ir,
    input  logic [DR_W-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DR_W-1:0] rsp_data,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [IR_W-1:0] ir_in,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_e1dr,
    output logic            jtag_state_rti
);

    localparam int c_HALF    = TCK_DIV / 2;
    localparam int c_DIV_W   = (TCK_DIV > 2) ? $clog2(TCK_DIV) : 1;
    localparam int c_SHIFT_W = $clog2(DR_W + 1);
    localparam int c_RTI_W   = $clog2(RTI_CYCLES + 1);
    localparam int c_CNT_W   = (c_SHIFT_W > c_RTI_W) ? c_SHIFT_W : c_RTI_W;

    // S_ARM: command latched, waiting for the next TCK fall to start
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_UIR  = 3'd2,
        S_CDR  = 3'd3,
        S_SDR  = 3'd4,
        S_E1DR = 3'd5,
        S_RTI  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [IR_W-1:0]      r_ir;
    logic [IR_W-1:0]      r_ir_in;
    logic [DR_W-1:0]      r_data;
    logic [DR_W-1:0]      r_rx;
    logic [DR_W-1:0]      r_rsp_data;
    logic                 r_rsp_valid;
    logic                 w_fall;
    logic                 w_rise;
    logic                 w_accept;
    logic                 w_last_shift;
    logic                 w_last_rti;
    logic                 w_ir_hit;

    assign w_fall       = (r_div_cnt == c_DIV_W'(TCK_DIV - 1));
    assign w_rise       = (r_div_cnt == c_DIV_W'(c_HALF - 1));
    assign w_accept     = cmd_valid && (r_state == S_IDLE);
    assign w_last_shift = (r_cnt == c_CNT_W'(DR_W - 1));
    assign w_last_rti   = (r_cnt == c_CNT_W'(RTI_CYCLES - 1));

`ifdef DEBUG_HOST_IR_CACHE_EN
    logic r_ir_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir_valid <= 1'b0;
        end else if (r_state == S_ARM && w_fall) begin
            r_ir_valid <= 1'b1;
        end
    end

    assign w_ir_hit = r_ir_valid && (r_ir == r_ir_in);
`else
    assign w_ir_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_fall) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_ARM;
            S_ARM:  if (w_fall) w_state_nxt = w_ir_hit ? S_CDR : S_UIR;
            S_UIR:  if (w_fall) w_state_nxt = S_CDR;
            S_CDR:  if (w_fall) w_state_nxt = S_SDR;
            S_SDR:  if (w_fall && w_last_shift) w_state_nxt = S_E1DR;
            S_E1DR: if (w_fall) w_state_nxt = S_RTI;
            S_RTI:  if (w_fall && w_last_rti) w_state_nxt = S_DONE;
            S_DONE: if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_ir        <= '0;
            r_ir_in     <= '0;
            r_data      <= '0;
            r_rx        <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ir   <= cmd_ir;
                r_data <= cmd_data;
            end
            if (w_fall) begin
                case (r_state)
                    S_ARM: begin
                        r_cnt <= '0;
                        if (!w_ir_hit) r_ir_in <= r_ir;
                    end
                    S_CDR:  r_cnt <= '0;
                    // data[0] is always the bit on tdi; advance once per period
                    S_SDR: begin
                        r_cnt  <= r_cnt + 1'b1;
                        r_data <= r_data >> 1;
                    end
                    S_E1DR: r_cnt <= '0;
                    S_RTI: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_rti) begin
                            r_rsp_data  <= r_rx;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_rise && r_state == S_SDR) begin
                r_rx <= {tdo, r_rx[DR_W-1:1]};
            end
            if (r_state == S_DONE && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign tck            = (r_div_cnt >= c_DIV_W'(c_HALF));
    assign tdi            = (r_state == S_SDR) && r_data[0];
    assign ir_in          = r_ir_in;
    assign vs_uir         = (r_state == S_UIR);
    assign vs_cdr         = (r_state == S_CDR);
    assign vs_sdr         = (r_state == S_SDR);
    assign vs_e1dr        = (r_state == S_E1DR);
    assign jtag_state_rti = (r_state == S_RTI);

endmodule

`default_nettype wire

// File: tb/tb_cpu_debug_jtag_host_seq.sv
// ============================================================================
// Module   : tb_cpu_debug_jtag_host_seq
// Brief    : Self-checking bench for cpu_debug_jtag_host_seq with a loopback /
//            capture-register slave model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_debug_jtag_host_seq;

    localparam int DR_W       = 38;
    localparam int IR_W       = 2;
    localparam int TCK_DIV    = 4;
    localparam int RTI_CYCLES = 2;
    localparam logic [DR_W-1:0] c_SR_VAL = 38'h3F_0000_00A5;
`ifdef DEBUG_HOST_IR_CACHE_EN
    localparam bit c_CACHE = 1'b1;
`else
    localparam bit c_CACHE = 1'b0;
`endif

    logic            clk;
    logic            reset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_data;
    logic            tck;
    logic            tdi;
    logic            tdo;
    logic [IR_W-1:0] ir_in;
    logic            vs_uir;
    logic            vs_cdr;
    logic            vs_sdr;
    logic            vs_e1dr;
    logic            jtag_state_rti;

    cpu_debug_jtag_host_seq #(
        .DR_W      (DR_W),
        .IR_W      (IR_W),
        .TCK_DIV   (TCK_DIV),
        .RTI_CYCLES(RTI_CYCLES)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_ir        (cmd_ir),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .tck           (tck),
        .tdi           (tdi),
        .tdo           (tdo),
        .ir_in         (ir_in),
        .vs_uir        (vs_uir),
        .vs_cdr        (vs_cdr),
        .vs_sdr        (vs_sdr),
        .vs_e1dr       (vs_e1dr),
        .jtag_state_rti(jtag_state_rti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: loopback (tdo = tdi one TCK later) or capture register
    logic            r_lb = 1'b0;
    logic [DR_W-1:0] r_sr = '0;
    bit              mode_sr = 1'b0;

    always @(posedge tck) begin
        r_lb <= tdi;
        if (vs_cdr)      r_sr <= c_SR_VAL;
        else if (vs_sdr) r_sr <= {1'b0, r_sr[DR_W-1:1]};
    end

    assign tdo = mode_sr ? r_sr[0] : r_lb;

    int              n_checks = 0;
    int              n_errors = 0;
    logic [DR_W-1:0] exp_q[$];
    bit              last_ir_valid = 1'b0;
    logic [IR_W-1:0] last_ir = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti,
                    rsp_valid, cmd_ready, rsp_data});
    endfunction

    // abort_at > 0: pull reset during SDR period abort_at instead of completing
    task automatic run_cmd(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] data,
                           input bit use_sr, input int hold, input int abort_at);
        logic [DR_W-1:0] exp_rsp;
        logic [DR_W-1:0] held;
        bit              exp_uir;
        bit              started;
        bit              prev_tck;
        bit              onehot_bad;
        bit              stable_bad;
        int              codes[$];
        int              exp_codes[$];
        int              t0;
        int              n;
        int              sdr_seen;
        int              seq_bad;

        exp_uir = !(c_CACHE && last_ir_valid && last_ir == ir);
        exp_rsp = use_sr ? c_SR_VAL : {data[DR_W-2:0], 1'b0};
        mode_sr = use_sr;

        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);

        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        exp_q.push_back(exp_rsp);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        last_ir       = ir;
        last_ir_valid = 1'b1;

        n = 0; started = 1'b0; prev_tck = tck; onehot_bad = 1'b0;
        sdr_seen = 0; t0 = 0;
        while (!rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
            if ($countones({vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti}) > 1) onehot_bad = 1'b1;
            if (!started && (vs_uir || vs_cdr)) begin
                started = 1'b1;
                t0      = cyc;
            end
            if (tck && !prev_tck) begin
                if (vs_uir)              codes.push_back(1);
                else if (vs_cdr)         codes.push_back(2);
                else if (vs_sdr)         codes.push_back(3);
                else if (vs_e1dr)        codes.push_back(4);
                else if (jtag_state_rti) codes.push_back(5);
                if (vs_sdr) sdr_seen++;
            end
            prev_tck = tck;
            if (abort_at > 0 && sdr_seen == abort_at + 1) break;
        end

        if (abort_at > 0) begin
            check_eq("abort_reached_sdr", 64'(vs_sdr), 64'd1);
            reset_n = 1'b0;
            #1;
            check_eq("abort_outputs", out_vec(), 64'd1 << DR_W);
            void'(exp_q.pop_back());
            last_ir_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            return;
        end

        check_eq("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        check_eq("latency_clks", 64'(cyc - t0), 64'((exp_uir ? 43 : 42) * TCK_DIV));
        check_eq("onehot", 64'(onehot_bad), 64'd0);

        if (exp_uir) exp_codes.push_back(1);
        exp_codes.push_back(2);
        for (int i = 0; i < DR_W; i++) exp_codes.push_back(3);
        exp_codes.push_back(4);
        for (int i = 0; i < RTI_CYCLES; i++) exp_codes.push_back(5);
        check_eq("seq_len", 64'(codes.size()), 64'(exp_codes.size()));
        seq_bad = 0;
        for (int i = 0; i < codes.size() && i < exp_codes.size(); i++)
            if (codes[i] != exp_codes[i]) seq_bad++;
        check_eq("seq_order", 64'(seq_bad), 64'd0);

        if (hold > 0) begin
            held       = rsp_data;
            stable_bad = 1'b0;
            cmd_valid  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_data !== held || cmd_ready) stable_bad = 1'b1;
            end
            cmd_valid = 1'b0;
            check_eq("hold_stable", 64'(stable_bad), 64'd0);
        end

        check_eq("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
        check_eq("ir_in", 64'(ir_in), 64'(ir));
        check_eq("done_strobes", 64'({tck & 1'b0, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti}), 64'd0);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq("rsp_valid_clear", 64'(rsp_valid), 64'd0);
        check_eq("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_ir    = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("reset_outputs", out_vec(), 64'd1 << DR_W);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(2'b01, 38'h15_5555_5555, 1'b0, 0, 0);
        run_cmd(2'b11, 38'h2A_1234_5678, 1'b0, 0, 0);
        run_cmd(2'b01, 38'h00_DEAD_BEEF, 1'b1, 0, 0);
        run_cmd(2'b11, 38'h12_3456_789A, 1'b1, 20, 0);
        run_cmd(2'b01, 38'h3F_FFFF_FFFF, 1'b0, 0, 10);
        run_cmd(2'b01, 38'h0C_0F0F_0F0F, 1'b0, 0, 0);
        run_cmd(2'b10, 38'h01_2345_6789, 1'b0, 0, 0);
        run_cmd(2'b10, 38'h1F_8001_7FFE, 1'b1, 0, 0);

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
